// File: rtl/mvau_pkg.sv
// Shared fold geometry for the MVAU weight-memory controller: default derivations, types, helpers.
package mvau_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int SIMD         = 2;
    localparam int PE           = 2;
    localparam int MATRIX_W     = 8;
    localparam int MATRIX_H     = 4;
    localparam int SF           = MATRIX_W / SIMD;
    localparam int NF           = MATRIX_H / PE;
    localparam int WMEM_DEPTH   = SF * NF;
    localparam int WMEM_ADDR_BW = clog2_min1(WMEM_DEPTH);

    typedef logic [WMEM_ADDR_BW-1:0]   wmem_addr_t;
    typedef logic [clog2_min1(SF)-1:0] sf_cnt_t;
    typedef logic [clog2_min1(NF)-1:0] nf_cnt_t;

endpackage

// File: rtl/mvau_fold_cnt.sv
// Two-level wrap counter: sf inner over SF folds, nf outer over NF folds; advances on en.
// Latency: counts and last flags are registered state, updated on the enabling edge.
// Backpressure: none of its own; the owner gates en.
module mvau_fold_cnt
    import mvau_pkg::*;
#(
    parameter  int SF    = 4,
    parameter  int NF    = 2,
    localparam int SF_BW = clog2_min1(SF),
    localparam int NF_BW = clog2_min1(NF)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             en,
    input  logic             clr,
    output logic [SF_BW-1:0] sf,
    output logic [NF_BW-1:0] nf,
    output logic             sf_last,
    output logic             nf_last
);

    // With a bound of 1 the counter sits at 0 and its last flag stays high.
    assign sf_last = (sf == SF_BW'(SF - 1));
    assign nf_last = (nf == NF_BW'(NF - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sf <= '0;
            nf <= '0;
        end else if (clr) begin
            sf <= '0;
            nf <= '0;
        end else if (en) begin
            if (sf_last) begin
                sf <= '0;
                nf <= nf_last ? '0 : nf + NF_BW'(1);
            end else begin
                sf <= sf + SF_BW'(1);
            end
        end
    end

endmodule

// File: rtl/mvau_weight_mem_ctrl.sv
// Sequences weight-memory reads (addr nf*SF+sf), one per accepted input word, with tags aligned to data.
// Latency: word for an issued address is valid one cycle after issue; full rate when out_rdy stays high.
// Backpressure: stalls in_rdy while the output word is unaccepted and re-presents the held address.
module mvau_weight_mem_ctrl
    import mvau_pkg::*;
#(
    parameter  int SIMD         = 2,
    parameter  int PE           = 2,
    parameter  int MatrixW      = 8,
    parameter  int MatrixH      = 4,
    localparam int SF           = MatrixW / SIMD,
    localparam int NF           = MatrixH / PE,
    localparam int WMEM_DEPTH   = SF * NF,
    localparam int WMEM_ADDR_BW = clog2_min1(WMEM_DEPTH)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    clr,
    input  logic                    in_v,
    output logic                    in_rdy,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    wmem_v,
    input  logic                    out_rdy,
    output logic                    sf_last,
    output logic                    nf_last,
    output logic                    vec_done
);

    localparam int SF_BW = clog2_min1(SF);
    localparam int NF_BW = clog2_min1(NF);

    logic [SF_BW-1:0]        sf;
    logic [NF_BW-1:0]        nf;
    logic                    cnt_sf_last;
    logic                    cnt_nf_last;
    logic                    issue;
    logic                    accept;
    logic [WMEM_ADDR_BW-1:0] fold_addr;
    logic [WMEM_ADDR_BW-1:0] hold_q;

    // aresetn in the issue term keeps in_rdy low for the whole reset window.
    assign issue     = aresetn & in_v & (~wmem_v | out_rdy) & ~clr;
    assign accept    = wmem_v & out_rdy;
    assign in_rdy    = issue;
    assign fold_addr = WMEM_ADDR_BW'(int'(nf) * SF + int'(sf));
    assign wmem_addr = issue ? fold_addr : hold_q;

    mvau_fold_cnt #(
        .SF (SF),
        .NF (NF)
    ) u_fold_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (issue),
        .clr     (clr),
        .sf      (sf),
        .nf      (nf),
        .sf_last (cnt_sf_last),
        .nf_last (cnt_nf_last)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_q   <= '0;
            wmem_v   <= 1'b0;
            sf_last  <= 1'b0;
            nf_last  <= 1'b0;
            vec_done <= 1'b0;
        end else if (clr) begin
            hold_q   <= '0;
            wmem_v   <= 1'b0;
            sf_last  <= 1'b0;
            nf_last  <= 1'b0;
            vec_done <= 1'b0;
        end else begin
            if (issue) begin
                hold_q  <= fold_addr;
                sf_last <= cnt_sf_last;
                nf_last <= cnt_nf_last;
            end
            wmem_v   <= issue | (wmem_v & ~out_rdy);
            vec_done <= accept & sf_last & nf_last;
        end
    end

    a_addr_range : assert property (@(posedge aclk) disable iff (!aresetn)
        int'(wmem_addr) < WMEM_DEPTH);

    // A stalled word must keep re-reading the same location.
    a_addr_hold : assert property (@(posedge aclk) disable iff (!aresetn)
        (wmem_v & ~out_rdy & ~in_v) |-> (wmem_addr == hold_q));

endmodule

// File: tb/tb_mvau_weight_mem_ctrl.sv
// Randomised and directed bench for mvau_weight_mem_ctrl against a word-sequence reference model.
module tb_mvau_weight_mem_ctrl;
    import mvau_pkg::*;

    logic                    aclk = 1'b0;
    logic                    aresetn;
    logic                    clr;
    logic                    in_v;
    logic                    in_rdy;
    logic [WMEM_ADDR_BW-1:0] wmem_addr;
    logic                    wmem_v;
    logic                    out_rdy;
    logic                    sf_last;
    logic                    nf_last;
    logic                    vec_done;
    logic [WMEM_ADDR_BW-1:0] wmem_out;

    int errors = 0;
    int checks = 0;

    // Reference model: next address to issue, word held at the memory output, last issued address.
    int  m_next, m_word, m_hold, m_acc;
    bit  m_v, m_vd;
    int  cyc = 0;
    int  vd_count, vd_first, vd_second;
    int  accepted;

    mvau_weight_mem_ctrl #(
        .SIMD    (SIMD),
        .PE      (PE),
        .MatrixW (MATRIX_W),
        .MatrixH (MATRIX_H)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clr       (clr),
        .in_v      (in_v),
        .in_rdy    (in_rdy),
        .wmem_addr (wmem_addr),
        .wmem_v    (wmem_v),
        .out_rdy   (out_rdy),
        .sf_last   (sf_last),
        .nf_last   (nf_last),
        .vec_done  (vec_done)
    );

    always #5 aclk = ~aclk;

    // Weight memory with mem[i] = i and one-cycle read latency.
    always @(posedge aclk) wmem_out <= wmem_addr;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_next = 0; m_word = 0; m_hold = 0; m_acc = 0; m_v = 0; m_vd = 0;
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance model across the next posedge.
    task automatic step(input bit v, input bit r, input bit c);
        bit exp_issue, acc;
        in_v = v; out_rdy = r; clr = c;
        @(negedge aclk);
        exp_issue = v && (!m_v || r) && !c;
        acc       = m_v && r;
        check("in_rdy", int'(in_rdy), int'(exp_issue));
        check("wmem_addr", int'(wmem_addr), exp_issue ? m_next : m_hold);
        check("wmem_v", int'(wmem_v), int'(m_v));
        check("vec_done", int'(vec_done), int'(m_vd));
        if (m_v) begin
            check("wmem_out", int'(wmem_out), m_word);
            check("sf_last", int'(sf_last), int'((m_word % SF) == SF - 1));
            check("nf_last", int'(nf_last), int'((m_word / SF) == NF - 1));
        end
        if (acc) begin
            check("order", int'(wmem_out), m_acc);
            m_acc = (m_acc + 1) % WMEM_DEPTH;
            accepted++;
        end
        if (vec_done === 1'b1) begin
            vd_count++;
            if (vd_count == 1) vd_first = cyc;
            if (vd_count == 2) vd_second = cyc;
        end
        if (c) begin
            model_reset();
        end else begin
            m_vd = acc && (m_word == WMEM_DEPTH - 1);
            if (exp_issue) begin
                m_word = m_next;
                m_hold = m_next;
                m_v    = 1;
                m_next = (m_next + 1) % WMEM_DEPTH;
            end else if (r) begin
                m_v = 0;
            end
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    initial begin
        aresetn = 1'b0; clr = 1'b0; in_v = 1'b1; out_rdy = 1'b1;
        model_reset();
        accepted = 0; vd_count = 0; vd_first = 0; vd_second = 0;
        repeat (3) @(posedge aclk);
        #2;
        check("rst_in_rdy", int'(in_rdy), 0);
        check("rst_wmem_v", int'(wmem_v), 0);
        check("rst_sf_last", int'(sf_last), 0);
        check("rst_nf_last", int'(nf_last), 0);
        check("rst_vec_done", int'(vec_done), 0);
        check("rst_addr", int'(wmem_addr), 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Streaming at full rate: two whole vectors plus the drain word.
        for (int i = 0; i < 18; i++) step(1, 1, 0);
        check("vd_count", vd_count, 2);
        check("vd_gap", vd_second - vd_first, WMEM_DEPTH);

        // Stall with word 2 at the output.
        step(1, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0);

        // Bubbly input.
        step(1, 1, 1);
        for (int i = 0; i < 10; i++) step(bit'(i % 2 == 0), 1, 0);

        // Async reset with word 5 in flight.
        step(1, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 1, 0);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_wmem_v", int'(wmem_v), 0);
        check("async_sf_last", int'(sf_last), 0);
        check("async_nf_last", int'(nf_last), 0);
        check("async_in_rdy", int'(in_rdy), 0);
        model_reset();
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 1, 0);

        // clr while address 6 is about to issue.
        step(1, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 1, 0);
        step(1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0);

        // Random handshake traffic.
        accepted = 0;
        for (int i = 0; i < 10000; i++)
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0), 0);
        check("random_progress", int'(accepted > 3000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
